// File: rtl/cpu_host_ctrl.sv
`timescale 1ns/1ps
// Host-side job sequencer for one A-RISC cpu run: loads IRAM/DRAM from a byte
// stream, starts the CPU, times the run and streams a DRAM window back out.
module cpu_host_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        cpu_start,
  input  logic        cpu_idle,
  input  logic        cpu_dram_write,
  input  logic [7:0]  cpu_dram_addr,
  input  logic [7:0]  cpu_dram_din,
  output logic        iram_we,
  output logic [7:0]  iram_waddr,
  output logic [15:0] iram_wdata,
  output logic        dram_write,
  output logic [7:0]  dram_addr,
  output logic [7:0]  dram_din,
  input  logic [7:0]  dram_dout,
  output logic        busy,
  output logic [15:0] run_cycles
);

  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_HDR2, S_ILOAD, S_DLOAD, S_START, S_RUN, S_RD, S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ni_q, ni_d;
  logic [7:0]  nd_q, nd_d;
  logic [7:0]  nr_q, nr_d;
  logic [7:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic [7:0]  lo_q, lo_d;
  logic        iwe_q, iwe_d;
  logic [7:0]  iaddr_q, iaddr_d;
  logic [15:0] idata_q, idata_d;
  logic        dwe_q, dwe_d;
  logic [7:0]  daddr_q, daddr_d;
  logic [7:0]  ddin_q, ddin_d;
  logic        start_q, start_d;
  logic [15:0] run_q, run_d;
  logic [7:0]  mdat_q, mdat_d;
  logic        ofirst_q, ofirst_d;
  logic        acc;

  assign s_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_HDR2) ||
                   (state_q == S_ILOAD) || (state_q == S_DLOAD);
  assign acc     = s_valid && s_ready;
  assign busy    = (state_q != S_HDR0);
  assign m_valid = (state_q == S_OUT);
  // Read data arrives during the first S_OUT cycle; present it directly, then hold the copy.
  assign m_data  = ofirst_q ? dram_dout : mdat_q;

  assign cpu_start  = start_q;
  assign run_cycles = run_q;
  assign iram_we    = iwe_q;
  assign iram_waddr = iaddr_q;
  assign iram_wdata = idata_q;

  always_comb begin
    if (state_q == S_RUN) begin
      dram_write = cpu_dram_write;
      dram_addr  = cpu_dram_addr;
      dram_din   = cpu_dram_din;
    end else begin
      dram_write = dwe_q;
      dram_addr  = daddr_q;
      dram_din   = ddin_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ni_d    = ni_q;
    nd_d    = nd_q;
    nr_d    = nr_q;
    idx_d   = idx_q;
    par_d   = par_q;
    lo_d    = lo_q;
    iwe_d   = 1'b0;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    dwe_d   = 1'b0;
    daddr_d = daddr_q;
    ddin_d  = ddin_q;
    run_d   = run_q;
    mdat_d  = mdat_q;

    case (state_q)
      S_HDR0: if (acc) begin
        ni_d    = s_data;
        state_d = S_HDR1;
      end
      S_HDR1: if (acc) begin
        nd_d    = s_data;
        state_d = S_HDR2;
      end
      S_HDR2: if (acc) begin
        nr_d = s_data;
        if (ni_q != 8'd0)      state_d = S_ILOAD;
        else if (nd_q != 8'd0) state_d = S_DLOAD;
        else                   state_d = S_START;
      end
      S_ILOAD: if (acc) begin
        if (!par_q) begin
          lo_d  = s_data;
          par_d = 1'b1;
        end else begin
          par_d   = 1'b0;
          iwe_d   = 1'b1;
          iaddr_d = idx_q;
          idata_d = {s_data, lo_q};
          if (idx_q == ni_q - 8'd1) begin
            idx_d   = '0;
            state_d = (nd_q != 8'd0) ? S_DLOAD : S_START;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_DLOAD: if (acc) begin
        dwe_d   = 1'b1;
        daddr_d = idx_q;
        ddin_d  = s_data;
        if (idx_q == nd_q - 8'd1) begin
          idx_d   = '0;
          state_d = S_START;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (cpu_idle) begin
          state_d = (nr_q != 8'd0) ? S_RD : S_HDR0;
        end else if (run_q != '1) begin
          run_d = run_q + 16'd1;
        end
      end
      S_RD: state_d = S_OUT;
      S_OUT: if (m_ready) begin
        if (idx_q == nr_q - 8'd1) begin
          idx_d   = '0;
          state_d = S_HDR0;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD;
        end
      end
      default: state_d = S_HDR0;
    endcase

    if (state_d == S_START && state_q != S_START) run_d = '0;
    if (state_d == S_RD) daddr_d = idx_d;
    if (ofirst_q) mdat_d = dram_dout;
    start_d  = (state_d == S_START);
    ofirst_d = (state_q == S_RD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_HDR0;
      ni_q     <= '0;
      nd_q     <= '0;
      nr_q     <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      lo_q     <= '0;
      iwe_q    <= 1'b0;
      iaddr_q  <= '0;
      idata_q  <= '0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      ddin_q   <= '0;
      start_q  <= 1'b0;
      run_q    <= '0;
      mdat_q   <= '0;
      ofirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ni_q     <= ni_d;
      nd_q     <= nd_d;
      nr_q     <= nr_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      lo_q     <= lo_d;
      iwe_q    <= iwe_d;
      iaddr_q  <= iaddr_d;
      idata_q  <= idata_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      ddin_q   <= ddin_d;
      start_q  <= start_d;
      run_q    <= run_d;
      mdat_q   <= mdat_d;
      ofirst_q <= ofirst_d;
    end
  end

endmodule
